// File: rtl/tff_toggle_debounce.sv
// Push-button conditioner for the T flip-flop: synchronizes, debounces and
// turns presses into one-cycle toggle enables, with optional auto-repeat.
module tff_toggle_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 0,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_in,
    output logic             t_pulse,
    output logic             rel_pulse,
    output logic             btn_level,
    output logic [CNT_W-1:0] press_cnt
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam int CNT_LAST_I = DEBOUNCE_CYCLES - 1;
    localparam int RPT_LAST_I = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CNT_LAST_I[CW-1:0];
    localparam logic [RW-1:0] RPT_LAST = RPT_LAST_I[RW-1:0];

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REL_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    rpt_q, rpt_d;
    logic             t_pulse_q, t_pulse_d;
    logic             rel_pulse_q, rel_pulse_d;
    logic             btn_level_q, btn_level_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic             btn_s;

    assign btn_s = sync2_q;

    always_comb begin
        state_d     = state_q;
        sync1_d     = btn_in;
        sync2_d     = sync1_q;
        cnt_d       = cnt_q;
        rpt_d       = rpt_q;
        t_pulse_d   = 1'b0;
        rel_pulse_d = 1'b0;
        btn_level_d = btn_level_q;
        press_cnt_d = press_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = HELD;
                    t_pulse_d   = 1'b1;
                    btn_level_d = 1'b1;
                    press_cnt_d = press_cnt_q + 1'b1;
                    rpt_d       = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = REL_WAIT;
                    cnt_d   = '0;
                end else if ((REPEAT_CYCLES > 0) && (rpt_q == RPT_LAST)) begin
                    t_pulse_d   = 1'b1;
                    press_cnt_d = press_cnt_q + 1'b1;
                    rpt_d       = '0;
                end else begin
                    rpt_d = rpt_q + 1'b1;
                end
            end
            REL_WAIT: begin
                // A bounce back to pressed resumes the repeat period where it left off
                if (btn_s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    rel_pulse_d = 1'b1;
                    btn_level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // With repeat disabled the repeat counter is pinned to zero and trims away
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            rpt_q       <= '0;
            t_pulse_q   <= 1'b0;
            rel_pulse_q <= 1'b0;
            btn_level_q <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            rpt_q       <= (REPEAT_CYCLES > 0) ? rpt_d : '0;
            t_pulse_q   <= t_pulse_d;
            rel_pulse_q <= rel_pulse_d;
            btn_level_q <= btn_level_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    assign t_pulse   = t_pulse_q;
    assign rel_pulse = rel_pulse_q;
    assign btn_level = btn_level_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_tff_toggle_debounce.sv
// Scoreboard bench for tff_toggle_debounce (D=4, R=10, CNT_W=2): stimulus
// queues timed pulse events, a negedge monitor pops and compares them.
module tb_tff_toggle_debounce;

    localparam int D = 4;
    localparam int R = 10;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         btn_in = 1'b0;
    logic         t_pulse;
    logic         rel_pulse;
    logic         btn_level;
    logic [W-1:0] press_cnt;

    tff_toggle_debounce #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_CYCLES  (R),
        .CNT_W          (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (btn_in),
        .t_pulse  (t_pulse),
        .rel_pulse(rel_pulse),
        .btn_level(btn_level),
        .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_rel;
        int at;
        int cnt;
        bit level;
    } ev_t;

    ev_t  exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;
    int   exp_toggles = 0;
    logic tff_q = 1'b0;
    ev_t  mon_ev;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream T flip-flop fed by the toggle enable
    always @(posedge clk) if (t_pulse) tff_q <= ~tff_q;

    task automatic check_output(input string name, input int actual, input int required);
        n_checks++;
        if (actual != required) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%0d required=%0d (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_t(input int at);
        ev_t e;
        exp_cnt = (exp_cnt + 1) % (1 << W);
        exp_toggles++;
        e.is_rel = 1'b0;
        e.at     = at;
        e.cnt    = exp_cnt;
        e.level  = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic push_rel(input int at);
        ev_t e;
        e.is_rel = 1'b1;
        e.at     = at;
        e.cnt    = exp_cnt;
        e.level  = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic v, output int c);
        btn_in = v;
        c      = cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_t_pulse"}, int'(t_pulse), 0);
        check_output({tag, "_rel_pulse"}, int'(rel_pulse), 0);
        check_output({tag, "_btn_level"}, int'(btn_level), 0);
        check_output({tag, "_press_cnt"}, int'(press_cnt), 0);
    endtask

    // Press at c0: t_pulse visible at c0+D+3, repeats every R after that,
    // rel_pulse visible D+3 after the release negedge
    task automatic press_release(input int hold, input int nrep);
        int c0;
        int c1;
        apply_stimulus(1'b1, c0);
        push_t(c0 + D + 3);
        for (int k = 1; k <= nrep; k++) push_t(c0 + D + 3 + R * k);
        wait_cycles(hold);
        apply_stimulus(1'b0, c1);
        push_rel(c1 + D + 3);
        wait_cycles(D + 8);
    endtask

    always @(negedge clk) begin
        if (t_pulse || rel_pulse) begin
            check_output("pulse_exclusive", int'(t_pulse & rel_pulse), 0);
            if (exp_q.size() == 0) begin
                check_output("unexpected_pulse", exp_q.size(), 1);
            end else begin
                mon_ev = exp_q.pop_front();
                check_output("pulse_kind_rel", int'(rel_pulse), int'(mon_ev.is_rel));
                check_output("pulse_cycle", cyc, mon_ev.at);
                check_output("pulse_press_cnt", int'(press_cnt), mon_ev.cnt);
                check_output("pulse_btn_level", int'(btn_level), int'(mon_ev.level));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        int c1;
        int r;
        int budget;

        wait_cycles(3);
        check_reset_outputs("por");
        rst_n = 1'b1;
        wait_cycles(3);

        press_release(12, 0);
        wait_cycles(4);

        apply_stimulus(1'b1, c0);
        wait_cycles(1);
        apply_stimulus(1'b0, c0);
        wait_cycles(1);
        apply_stimulus(1'b1, c0);
        wait_cycles(1);
        apply_stimulus(1'b0, c0);
        wait_cycles(12);
        check_output("bounce_btn_level", int'(btn_level), 0);
        check_output("bounce_press_cnt", int'(press_cnt), exp_cnt);
        press_release(12, 0);
        wait_cycles(4);

        // 2-cycle release glitch while held; repeat period is frozen during REL_WAIT
        apply_stimulus(1'b1, c0);
        push_t(c0 + D + 3);
        wait_cycles(9);
        apply_stimulus(1'b0, c1);
        wait_cycles(2);
        apply_stimulus(1'b1, c1);
        wait_cycles(2);
        check_output("glitch_btn_level", int'(btn_level), 1);
        push_t(c0 + 20);
        wait_cycles(7);
        apply_stimulus(1'b0, c1);
        push_rel(c1 + D + 3);
        wait_cycles(D + 8);

        press_release(47, 4);
        wait_cycles(4);

        rst_n = 1'b0;
        wait_cycles(2);
        check_reset_outputs("mid_reset");
        rst_n = 1'b1;
        exp_cnt = 0;
        wait_cycles(3);
        for (int i = 0; i < 5; i++) begin
            press_release(12, 0);
            wait_cycles(2);
        end

        // Reset asserted while HELD with the button still down
        apply_stimulus(1'b1, c0);
        push_t(c0 + D + 3);
        wait_cycles(10);
        rst_n = 1'b0;
        wait_cycles(1);
        check_reset_outputs("held_reset");
        wait_cycles(2);
        rst_n = 1'b1;
        r = cyc;
        exp_cnt = 0;
        push_t(r + D + 3);
        wait_cycles(12);
        apply_stimulus(1'b0, c1);
        push_rel(c1 + D + 3);
        wait_cycles(D + 8);

        budget = 100;
        while (exp_q.size() != 0 && budget > 0) begin
            wait_cycles(1);
            budget--;
        end
        check_output("queue_drained", exp_q.size(), 0);
        check_output("tff_q_parity", int'(tff_q), exp_toggles % 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
